out_port_arbiter: RTL and testbench



---
 rtl/out_port_arbiter_pkg.sv | 20 ++
 rtl/out_port_arbiter_if.sv | 36 +++
 rtl/out_port_arbiter_rr_pick4.sv | 32 +++
 rtl/out_port_arbiter.sv | 101 ++++++++++
 tb/tb_out_port_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/out_port_arbiter_pkg.sv
// out_arb_pkg: shared constants and types for the egress-side arbiters.
//   NUM_PORTS     requester count for the 4:1 arbiters
//   EOP_BIT       end-of-packet bit position in the default-width control word
//   PORT_SEL_*    egress port field of the control word
//   port_idx_t    2-bit requester/port index
//   lock_state_e  packet-lock state (only used when OUT_ARB_PKT_LOCK_EN is defined)
package out_arb_pkg;
  localparam int NUM_PORTS    = 4;
  localparam int CTRL_W_DEF   = 32;
  localparam int EOP_BIT      = CTRL_W_DEF - 1;
  localparam int PORT_SEL_LSB = 0;
  localparam int PORT_SEL_MSB = 1;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;
endpackage

// File: rtl/out_port_arbiter_if.sv
// out_port_arbiter_if: four requester streams in, one egress stream out.
//   in_wr/in_ctl/in_data/in_rdy 0..3  requester handshakes (in_rdy = accepted)
//   out_wr/out_ctl/out_data/out_rdy   egress handshake toward the switch input
//   slave  : arbiter view
//   master : requester + downstream (environment) view
interface out_port_arbiter_if #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32
) ();
  logic                  in_wr0, in_wr1, in_wr2, in_wr3;
  logic [CTRL_WIDTH-1:0] in_ctl0, in_ctl1, in_ctl2, in_ctl3;
  logic [DATA_WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic                  in_rdy0, in_rdy1, in_rdy2, in_rdy3;
  logic                  out_wr;
  logic [CTRL_WIDTH-1:0] out_ctl;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_rdy;

  modport slave (
    input  in_wr0, in_wr1, in_wr2, in_wr3,
    input  in_ctl0, in_ctl1, in_ctl2, in_ctl3,
    input  in_data0, in_data1, in_data2, in_data3,
    output in_rdy0, in_rdy1, in_rdy2, in_rdy3,
    output out_wr, out_ctl, out_data,
    input  out_rdy
  );

  modport master (
    output in_wr0, in_wr1, in_wr2, in_wr3,
    output in_ctl0, in_ctl1, in_ctl2, in_ctl3,
    output in_data0, in_data1, in_data2, in_data3,
    input  in_rdy0, in_rdy1, in_rdy2, in_rdy3,
    input  out_wr, out_ctl, out_data,
    output out_rdy
  );
endinterface

// File: rtl/out_port_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way rotating-priority pick.
//   req        requests
//   ptr        highest-priority index; search goes ptr, ptr+1, ptr+2, ptr+3
//   gnt_onehot one-hot winner (zero when no request)
//   gnt_idx    winner index (ptr when no request)
//   any        at least one request present
module rr_pick4
  import out_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] gnt_onehot,
  output port_idx_t            gnt_idx,
  output logic                 any
);
  port_idx_t cand;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = ptr;
    any        = 1'b0;
    cand       = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = ptr + port_idx_t'(k);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter: 4:1 round-robin merge of requester beats into one
// registered egress stage with backpressure.
//   clk, rst  clock, asynchronous active-low reset
//   bus       out_port_arbiter_if.slave (requesters 0..3 in, egress out)
// Optional: OUT_ARB_PKT_LOCK_EN keeps the grant on one port from the first
// non-EOP beat until its EOP beat, so multi-beat packets are not interleaved.
module out_port_arbiter
  import out_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  out_port_arbiter_if.slave bus
);
  logic [NUM_PORTS-1:0]                 req, req_elig, gnt_onehot, rdy_vec;
  logic [NUM_PORTS-1:0][CTRL_WIDTH-1:0] ctl;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data;
  port_idx_t                            ptr, gnt_idx;
  logic                                 any, load_en;
  logic                                 out_wr_q;
  logic [CTRL_WIDTH-1:0]                out_ctl_q;
  logic [DATA_WIDTH-1:0]                out_data_q;

  assign req  = {bus.in_wr3, bus.in_wr2, bus.in_wr1, bus.in_wr0};
  assign ctl  = {bus.in_ctl3, bus.in_ctl2, bus.in_ctl1, bus.in_ctl0};
  assign data = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};

  // Output stage is free when empty or being drained this cycle.
  assign load_en = !out_wr_q || bus.out_rdy;

  rr_pick4 u_pick (
    .req       (req_elig),
    .ptr       (ptr),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any       (any)
  );

  // rst gate keeps in_rdy low during reset even though load_en is high then.
  assign rdy_vec = gnt_onehot & {NUM_PORTS{load_en & rst}};
  assign {bus.in_rdy3, bus.in_rdy2, bus.in_rdy1, bus.in_rdy0} = rdy_vec;

`ifdef OUT_ARB_PKT_LOCK_EN
  lock_state_e lock_st;
  port_idx_t   lock_port;
  logic        eop;

  assign eop = ctl[gnt_idx][CTRL_WIDTH-1];

  // While locked only the owning port is eligible, even if it is idle.
  always_comb begin
    req_elig = req;
    if (lock_st == LOCKED) req_elig = req & (NUM_PORTS'(1) << lock_port);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_st   <= UNLOCKED;
      lock_port <= '0;
    end else if (load_en && any) begin
      case (lock_st)
        UNLOCKED: if (!eop) begin
          lock_st   <= LOCKED;
          lock_port <= gnt_idx;
        end
        LOCKED:   if (eop) lock_st <= UNLOCKED;
        default:  lock_st <= UNLOCKED;
      endcase
    end
  end
`else
  assign req_elig = req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_q   <= 1'b0;
      out_ctl_q  <= '0;
      out_data_q <= '0;
      ptr        <= '0;
    end else if (load_en) begin
      out_wr_q <= any;
      if (any) begin
        out_ctl_q  <= ctl[gnt_idx];
        out_data_q <= data[gnt_idx];
`ifdef OUT_ARB_PKT_LOCK_EN
        // Rotation only moves at packet boundaries.
        if (eop) ptr <= gnt_idx + 2'd1;
`else
        ptr <= gnt_idx + 2'd1;
`endif
      end
    end
  end

  assign bus.out_wr   = out_wr_q;
  assign bus.out_ctl  = out_ctl_q;
  assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: scoreboard bench for out_port_arbiter. Requesters are
// per-port beat queues; expected egress beats are queued in the order the
// arbitration rules dictate and popped on each output transfer.
module tb_out_port_arbiter;
  localparam int DW = 480;
  localparam int CW = 32;

  typedef struct packed {
    logic        eop;
    logic [15:0] tag;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  out_port_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();
  out_port_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [3:0]         tb_wr, en;
  logic [3:0][CW-1:0] tb_ctl;
  logic [3:0][DW-1:0] tb_data;
  logic               out_rdy;

  assign {bus.in_wr3, bus.in_wr2, bus.in_wr1, bus.in_wr0} = tb_wr;
  assign bus.in_ctl0 = tb_ctl[0];  assign bus.in_data0 = tb_data[0];
  assign bus.in_ctl1 = tb_ctl[1];  assign bus.in_data1 = tb_data[1];
  assign bus.in_ctl2 = tb_ctl[2];  assign bus.in_data2 = tb_data[2];
  assign bus.in_ctl3 = tb_ctl[3];  assign bus.in_data3 = tb_data[3];
  assign bus.out_rdy = out_rdy;

  wire [3:0] rdy = {bus.in_rdy3, bus.in_rdy2, bus.in_rdy1, bus.in_rdy0};

  beat_t       src_q[4][$];
  beat_t       exp_q[$];
  int          n_chk, n_fail, n;
  int          gcnt[4];
  logic [3:0]  s_rdy;
  logic        s_wr;
  logic [63:0] s_data;

  function automatic logic [CW-1:0] ctl_of(beat_t b);
    return {b.eop, 15'd0, b.tag};
  endfunction

  function automatic logic [DW-1:0] data_of(beat_t b);
    return {30{b.tag}};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic src(int p, logic [15:0] tag, logic eop);
    beat_t b;
    b.eop = eop;
    b.tag = tag;
    src_q[p].push_back(b);
  endtask

  task automatic exp_beat(logic [15:0] tag, logic eop);
    beat_t b;
    b.eop = eop;
    b.tag = tag;
    exp_q.push_back(b);
  endtask

  // One clock: present queue heads, sample just before the edge, retire
  // accepted beats just after it.
  task automatic cyc();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      tb_wr[i] = en[i] && (src_q[i].size() > 0);
      if (src_q[i].size() > 0) begin
        tb_ctl[i]  = ctl_of(src_q[i][0]);
        tb_data[i] = data_of(src_q[i][0]);
      end
    end
    #3;
    s_rdy  = rdy;
    s_wr   = bus.out_wr;
    s_data = bus.out_data[63:0];
    chk("rdy_onehot", ($countones(rdy) <= 1) ? 64'd1 : 64'd0, 64'd1);
    chk("rdy_without_wr", 64'(rdy & ~tb_wr), 64'd0);
    if (bus.out_wr && out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", bus.out_data[63:0], 64'd0);
      end else begin
        b = exp_q.pop_front();
        chk("out_ctl", 64'(bus.out_ctl), 64'(ctl_of(b)));
        chk("out_data", bus.out_data[63:0], {4{b.tag}});
        chk("out_data_hi", 64'(bus.out_data[DW-1:DW-16]), 64'(b.tag));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (s_rdy[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        gcnt[i]++;
      end
  endtask

  task automatic run(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      cyc();
      cycles++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    en = 4'hf; out_rdy = 1'b1;
    tb_wr = '0; tb_ctl = '0; tb_data = '0;

    // Reset state with all requesters asserting.
    #2;
    tb_wr = 4'hf;
    for (int i = 0; i < 4; i++) begin
      tb_ctl[i]  = CW'(32'h8000_0011);
      tb_data[i] = {30{16'h5a5a}};
    end
    #10;
    chk("rst_out_wr", 64'(bus.out_wr), 64'd0);
    chk("rst_out_ctl", 64'(bus.out_ctl), 64'd0);
    chk("rst_out_data", bus.out_data[63:0], 64'd0);
    chk("rst_in_rdy", 64'(rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tb_wr = '0;

    // All four requesting: grants rotate 0,1,2,3 at one beat per cycle.
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 4; p++) begin
        src(p, 16'(16'h0100 + p * 16 + k), 1'b1);
        exp_beat(16'(16'h0100 + p * 16 + k), 1'b1);
      end
    cyc();
    chk("t1_first_rdy", 64'(s_rdy), 64'b0001);
    chk("t1_first_wr", 64'(s_wr), 64'd0);
    cyc();
    chk("t1_wr_rise", 64'(s_wr), 64'd1);
    chk("t1_second_rdy", 64'(s_rdy), 64'b0010);
    run(40, n);
    chk("t1_cycles", 64'(n + 2), 64'd13);

    // Port 2 alone: A, B, C back to back.
    begin
      int g2;
      g2 = gcnt[2];
      src(2, 16'h000A, 1'b1); src(2, 16'h000B, 1'b1); src(2, 16'h000C, 1'b1);
      exp_beat(16'h000A, 1'b1); exp_beat(16'h000B, 1'b1); exp_beat(16'h000C, 1'b1);
      run(20, n);
      chk("t2_cycles", 64'(n), 64'd4);
      chk("t2_rdy2_count", 64'(gcnt[2] - g2), 64'd3);
    end

    // Pointer now at 3: ports 0,1,3 resolve as 3,0,1.
    src(0, 16'h0200, 1'b1); src(1, 16'h0210, 1'b1); src(3, 16'h0230, 1'b1);
    exp_beat(16'h0230, 1'b1); exp_beat(16'h0200, 1'b1); exp_beat(16'h0210, 1'b1);
    run(20, n);

    // Backpressure: held output, no grants, then drain+load with no bubble.
    src(0, 16'h0300, 1'b1); src(0, 16'h0301, 1'b1);
    src(1, 16'h0310, 1'b1); src(1, 16'h0311, 1'b1);
    exp_beat(16'h0300, 1'b1); exp_beat(16'h0310, 1'b1);
    exp_beat(16'h0301, 1'b1); exp_beat(16'h0311, 1'b1);
    cyc();
    chk("t3_first_grant", 64'(s_rdy), 64'b0001);
    out_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t3_hold_rdy", 64'(s_rdy), 64'd0);
      chk("t3_hold_wr", 64'(s_wr), 64'd1);
      chk("t3_hold_data", s_data, {4{16'h0300}});
    end
    out_rdy = 1'b1;
    cyc();
    chk("t3_no_bubble", 64'(s_rdy), 64'b0010);
    run(20, n);

    // Reset pulse with a beat in the output register.
    en = 4'b1110;
    src(2, 16'h0420, 1'b1); src(2, 16'h0421, 1'b1);
    src(3, 16'h0430, 1'b1); src(0, 16'h0400, 1'b1);
    out_rdy = 1'b0;
    cyc();
    chk("t4_grant2", 64'(s_rdy), 64'b0100);
    chk("t4_wr_before_rst", 64'(bus.out_wr), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("t4_rst_out_wr", 64'(bus.out_wr), 64'd0);
    chk("t4_rst_out_ctl", 64'(bus.out_ctl), 64'd0);
    chk("t4_rst_out_data", bus.out_data[63:0], 64'd0);
    @(posedge clk); #1;
    chk("t4_rdy_in_rst", 64'(rdy), 64'd0);
    rst = 1'b1; en = 4'hf; out_rdy = 1'b1;
    exp_beat(16'h0400, 1'b1); exp_beat(16'h0421, 1'b1); exp_beat(16'h0430, 1'b1);
    cyc();
    chk("t4_first_after_rst", 64'(s_rdy), 64'b0001);
    run(20, n);

    // Port 1 three-beat packet while port 3 requests throughout.
    src(1, 16'h0510, 1'b0); src(1, 16'h0511, 1'b0); src(1, 16'h0512, 1'b1);
    src(3, 16'h0530, 1'b1); src(3, 16'h0531, 1'b1);
`ifdef OUT_ARB_PKT_LOCK_EN
    exp_beat(16'h0510, 1'b0); exp_beat(16'h0511, 1'b0); exp_beat(16'h0512, 1'b1);
    exp_beat(16'h0530, 1'b1); exp_beat(16'h0531, 1'b1);
`else
    exp_beat(16'h0510, 1'b0); exp_beat(16'h0530, 1'b1); exp_beat(16'h0511, 1'b0);
    exp_beat(16'h0531, 1'b1); exp_beat(16'h0512, 1'b1);
`endif
    run(30, n);

    // Port 0 goes idle mid-packet while port 2 requests.
    en = 4'b0001;
    src(0, 16'h0600, 1'b0); src(0, 16'h0601, 1'b1); src(2, 16'h0620, 1'b1);
`ifdef OUT_ARB_PKT_LOCK_EN
    exp_beat(16'h0600, 1'b0); exp_beat(16'h0601, 1'b1); exp_beat(16'h0620, 1'b1);
`else
    exp_beat(16'h0600, 1'b0); exp_beat(16'h0620, 1'b1); exp_beat(16'h0601, 1'b1);
`endif
    cyc();
    chk("t6_first_grant", 64'(s_rdy), 64'b0001);
    en = 4'b0100;
    cyc();
`ifdef OUT_ARB_PKT_LOCK_EN
    chk("t6_idle1_rdy", 64'(s_rdy), 64'd0);
`else
    chk("t6_idle1_rdy", 64'(s_rdy), 64'b0100);
`endif
    cyc();
    chk("t6_idle2_rdy", 64'(s_rdy), 64'd0);
    en = 4'hf;
    run(20, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
